// File: rtl/presents_manager.sv
// presents_manager: owns the three on-screen presents -- spawn allocation, per-frame
// fall/land/blink timing, and serialisation of collections into reward pulses.
module presents_manager #(
  parameter int FLOOR_Y       = 400,
  parameter int PRESENT_H     = 16,
  parameter int FALL_STEP     = 2,
  parameter int LAND_FRAMES   = 180,
  parameter int BLINK_FRAMES  = 60,
  parameter bit ROPE_COLLECTS = 1'b0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        clearAll,
  input  logic        spawnReq,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic [2:0]  colPlayer,
  input  logic [2:0]  colRope,
  output logic [2:0]  presentActive,
  output logic [2:0]  presentVisible,
  output logic [10:0] topLeftX0,
  output logic [10:0] topLeftX1,
  output logic [10:0] topLeftX2,
  output logic [10:0] topLeftY0,
  output logic [10:0] topLeftY1,
  output logic [10:0] topLeftY2,
  output logic [1:0]  presentType0,
  output logic [1:0]  presentType1,
  output logic [1:0]  presentType2,
  output logic        rewardValid,
  output logic [1:0]  rewardType,
  output logic        spawnDropped
);

  localparam int NUM_SLOTS = 3;
  localparam int CNT_MAX   = (LAND_FRAMES > BLINK_FRAMES) ? LAND_FRAMES : BLINK_FRAMES;
  localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
  localparam int CNT_W     = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

  localparam logic [11:0]      REST_Y     = 12'(FLOOR_Y - PRESENT_H);
  localparam logic [11:0]      STEP       = 12'(FALL_STEP);
  localparam logic [CNT_W-1:0] LAND_LOAD  = CNT_W'(LAND_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FALLING = 2'd1,
    S_LANDED  = 2'd2,
    S_BLINK   = 2'd3
  } slot_state_t;

  slot_state_t      state_q [NUM_SLOTS];
  slot_state_t      state_d [NUM_SLOTS];
  logic [10:0]      x_q     [NUM_SLOTS];
  logic [10:0]      x_d     [NUM_SLOTS];
  logic [10:0]      y_q     [NUM_SLOTS];
  logic [10:0]      y_d     [NUM_SLOTS];
  logic [1:0]       ptype_q [NUM_SLOTS];
  logic [1:0]       ptype_d [NUM_SLOTS];
  logic [CNT_W-1:0] cnt_q   [NUM_SLOTS];
  logic [CNT_W-1:0] cnt_d   [NUM_SLOTS];
  logic [11:0]      fall_y  [NUM_SLOTS];

  logic [2:0] pending_q, pending_d;
  logic [2:0] visible_q, visible_d;
  logic [2:0] idle_mask, hits, eff_pending, grant, alloc;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] new_type;
  logic       reward_valid_q, reward_valid_d;
  logic [1:0] reward_type_q, reward_type_d;
  logic       spawn_dropped_q, spawn_dropped_d;

  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign new_type = (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0];

  always_comb begin
    idle_mask = '0;
    hits      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idle_mask[i] = (state_q[i] == S_IDLE);
      hits[i]      = (state_q[i] != S_IDLE) &&
                     (colPlayer[i] || (ROPE_COLLECTS && colRope[i]));
      fall_y[i]    = {1'b0, y_q[i]} + STEP;
    end
  end

  // Same-cycle collisions join the pending set so a single hit rewards next cycle.
  assign eff_pending = pending_q | hits;

  always_comb begin
    grant = '0;
    alloc = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (eff_pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
      if (idle_mask[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      ptype_d[i] = ptype_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    pending_d       = pending_q;
    reward_valid_d  = 1'b0;
    reward_type_d   = 2'b00;
    spawn_dropped_d = 1'b0;
    visible_d       = '0;

    if (clearAll) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
      end
      pending_d = '0;
    end else begin
      pending_d       = eff_pending & ~grant;
      reward_valid_d  = (grant != 3'b000);
      spawn_dropped_d = spawnReq && (idle_mask == 3'b000);
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (grant[i]) begin
          reward_type_d = ptype_q[i];
          state_d[i]    = S_IDLE;
          cnt_d[i]      = '0;
        end else if (alloc[i] && spawnReq) begin
          state_d[i] = S_FALLING;
          x_d[i]     = spawnX;
          y_d[i]     = spawnY;
          ptype_d[i] = new_type;
          cnt_d[i]   = '0;
        end else if (startOfFrame && !eff_pending[i]) begin
          // Slots waiting for their reward are frozen so they cannot expire first.
          case (state_q[i])
            S_FALLING: begin
              if (fall_y[i] >= REST_Y) begin
                y_d[i]     = REST_Y[10:0];
                state_d[i] = S_LANDED;
                cnt_d[i]   = LAND_LOAD;
              end else begin
                y_d[i] = fall_y[i][10:0];
              end
            end
            S_LANDED: begin
              if (cnt_q[i] == '0) begin
                state_d[i] = S_BLINK;
                cnt_d[i]   = BLINK_LOAD;
              end else begin
                cnt_d[i] = cnt_q[i] - 1'b1;
              end
            end
            S_BLINK: begin
              if (cnt_q[i] == '0) begin
                state_d[i] = S_IDLE;
              end else begin
                cnt_d[i] = cnt_q[i] - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      case (state_d[i])
        S_FALLING, S_LANDED: visible_d[i] = 1'b1;
        S_BLINK:             visible_d[i] = cnt_d[i][3];
        default:             visible_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        ptype_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      pending_q       <= '0;
      visible_q       <= '0;
      lfsr_q          <= 8'hA5;
      reward_valid_q  <= 1'b0;
      reward_type_q   <= 2'b00;
      spawn_dropped_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        ptype_q[i] <= ptype_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pending_q       <= pending_d;
      visible_q       <= visible_d;
      lfsr_q          <= lfsr_d;
      reward_valid_q  <= reward_valid_d;
      reward_type_q   <= reward_type_d;
      spawn_dropped_q <= spawn_dropped_d;
    end
  end

  always_comb begin
    presentActive = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      presentActive[i] = (state_q[i] != S_IDLE);
    end
  end

  assign presentVisible = visible_q;
  assign topLeftX0      = x_q[0];
  assign topLeftX1      = x_q[1];
  assign topLeftX2      = x_q[2];
  assign topLeftY0      = y_q[0];
  assign topLeftY1      = y_q[1];
  assign topLeftY2      = y_q[2];
  assign presentType0   = ptype_q[0];
  assign presentType1   = ptype_q[1];
  assign presentType2   = ptype_q[2];
  assign rewardValid    = reward_valid_q;
  assign rewardType     = reward_type_q;
  assign spawnDropped   = spawn_dropped_q;

endmodule

// File: tb/tb_presents_manager.sv
// Directed bench for presents_manager: lifecycle, allocation, collect serialisation,
// rope option, clearAll, async reset and below-floor spawn.
module tb_presents_manager;

  localparam int ST_LANDED = 2;
  localparam int ST_BLINK  = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame, clearAll, spawnReq;
  logic [10:0] spawnX, spawnY;
  logic [2:0]  colPlayer, colRope;

  logic [2:0]  presentActive, presentVisible;
  logic [10:0] topLeftX0, topLeftX1, topLeftX2, topLeftY0, topLeftY1, topLeftY2;
  logic [1:0]  presentType0, presentType1, presentType2;
  logic        rewardValid, spawnDropped;
  logic [1:0]  rewardType;

  logic [2:0]  r_presentActive, r_presentVisible;
  logic [10:0] r_topLeftX0, r_topLeftX1, r_topLeftX2, r_topLeftY0, r_topLeftY1, r_topLeftY2;
  logic [1:0]  r_presentType0, r_presentType1, r_presentType2;
  logic        r_rewardValid, r_spawnDropped;
  logic [1:0]  r_rewardType;

  logic [7:0]  m_lfsr;
  logic [1:0]  t0, t1, t2;
  int          check_count = 0;
  int          pass_count = 0;

  always #5 clk = ~clk;

  // Reference type generator running alongside the DUT from the same reset.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) m_lfsr <= 8'hA5;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  presents_manager #(.ROPE_COLLECTS(1'b0)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .clearAll(clearAll),
    .spawnReq(spawnReq), .spawnX(spawnX), .spawnY(spawnY),
    .colPlayer(colPlayer), .colRope(colRope),
    .presentActive(presentActive), .presentVisible(presentVisible),
    .topLeftX0(topLeftX0), .topLeftX1(topLeftX1), .topLeftX2(topLeftX2),
    .topLeftY0(topLeftY0), .topLeftY1(topLeftY1), .topLeftY2(topLeftY2),
    .presentType0(presentType0), .presentType1(presentType1), .presentType2(presentType2),
    .rewardValid(rewardValid), .rewardType(rewardType), .spawnDropped(spawnDropped)
  );

  presents_manager #(.ROPE_COLLECTS(1'b1)) dut_r (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .clearAll(clearAll),
    .spawnReq(spawnReq), .spawnX(spawnX), .spawnY(spawnY),
    .colPlayer(colPlayer), .colRope(colRope),
    .presentActive(r_presentActive), .presentVisible(r_presentVisible),
    .topLeftX0(r_topLeftX0), .topLeftX1(r_topLeftX1), .topLeftX2(r_topLeftX2),
    .topLeftY0(r_topLeftY0), .topLeftY1(r_topLeftY1), .topLeftY2(r_topLeftY2),
    .presentType0(r_presentType0), .presentType1(r_presentType1), .presentType2(r_presentType2),
    .rewardValid(r_rewardValid), .rewardType(r_rewardType), .spawnDropped(r_spawnDropped)
  );

  function automatic logic [1:0] mapType(input logic [7:0] l);
    return (l[1:0] == 2'b11) ? 2'b00 : l[1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Drive one cycle of inputs, then return #1 after the edge that consumed them.
  task automatic applyStimulus(input logic spawn, input logic [10:0] sx, input logic [10:0] sy,
                               input logic [2:0] cp, input logic [2:0] cr,
                               input logic sof, input logic clr);
    spawnReq     = spawn;
    spawnX       = sx;
    spawnY       = sy;
    colPlayer    = cp;
    colRope      = cr;
    startOfFrame = sof;
    clearAll     = clr;
    @(posedge clk);
    #1;
    spawnReq     = 1'b0;
    colPlayer    = 3'b000;
    colRope      = 3'b000;
    startOfFrame = 1'b0;
    clearAll     = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 11'd0, 11'd0, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 11'd0, 11'd0, 3'b000, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic spawnAt(input logic [10:0] sx, input logic [10:0] sy);
    applyStimulus(1'b1, sx, sy, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    startOfFrame = 1'b0; clearAll = 1'b0; spawnReq = 1'b0;
    spawnX = '0; spawnY = '0; colPlayer = '0; colRope = '0;

    @(posedge clk); #1;
    checkOutput("reset_active", 32'(presentActive), 32'd0);
    checkOutput("reset_visible", 32'(presentVisible), 32'd0);
    checkOutput("reset_reward", 32'(rewardValid), 32'd0);
    checkOutput("reset_dropped", 32'(spawnDropped), 32'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    idleCycle();
    checkOutput("post_reset_active", 32'(presentActive), 32'd0);

    $display("[TB] lifecycle");
    t0 = mapType(m_lfsr);
    spawnAt(11'd100, 11'd50);
    checkOutput("spawn_active", 32'(presentActive), 32'b001);
    checkOutput("spawn_visible", 32'(presentVisible), 32'b001);
    checkOutput("spawn_x0", 32'(topLeftX0), 32'd100);
    checkOutput("spawn_y0", 32'(topLeftY0), 32'd50);
    checkOutput("spawn_type0", 32'(presentType0), 32'(t0));
    frames(166);
    checkOutput("fall_y0_166", 32'(topLeftY0), 32'd382);
    frames(1);
    checkOutput("land_y0", 32'(topLeftY0), 32'd384);
    checkOutput("land_state", 32'(dut.state_q[0]), ST_LANDED);
    frames(179);
    checkOutput("landed_hold_state", 32'(dut.state_q[0]), ST_LANDED);
    checkOutput("landed_visible", 32'(presentVisible), 32'b001);
    frames(1);
    checkOutput("blink_state", 32'(dut.state_q[0]), ST_BLINK);
    checkOutput("blink_vis_59", 32'(presentVisible), 32'b001);
    frames(4);
    checkOutput("blink_vis_55", 32'(presentVisible), 32'b000);
    frames(8);
    checkOutput("blink_vis_47", 32'(presentVisible), 32'b001);
    frames(47);
    checkOutput("blink_last_active", 32'(presentActive), 32'b001);
    frames(1);
    checkOutput("expire_active", 32'(presentActive), 32'b000);
    checkOutput("expire_visible", 32'(presentVisible), 32'b000);

    $display("[TB] allocation");
    t0 = mapType(m_lfsr);
    spawnAt(11'd10, 11'd20);
    checkOutput("alloc0_active", 32'(presentActive), 32'b001);
    checkOutput("alloc0_type", 32'(presentType0), 32'(t0));
    t1 = mapType(m_lfsr);
    spawnAt(11'd30, 11'd40);
    checkOutput("alloc1_active", 32'(presentActive), 32'b011);
    checkOutput("alloc1_x1", 32'(topLeftX1), 32'd30);
    checkOutput("alloc1_type", 32'(presentType1), 32'(t1));
    t2 = mapType(m_lfsr);
    spawnAt(11'd50, 11'd60);
    checkOutput("alloc2_active", 32'(presentActive), 32'b111);
    checkOutput("alloc2_y2", 32'(topLeftY2), 32'd60);
    checkOutput("alloc2_type", 32'(presentType2), 32'(t2));
    checkOutput("alloc2_no_drop", 32'(spawnDropped), 32'd0);
    spawnAt(11'd70, 11'd80);
    checkOutput("full_dropped", 32'(spawnDropped), 32'd1);
    checkOutput("full_active", 32'(presentActive), 32'b111);
    checkOutput("full_x2_kept", 32'(topLeftX2), 32'd50);
    idleCycle();
    checkOutput("dropped_pulse_end", 32'(spawnDropped), 32'd0);

    $display("[TB] collect serialiser");
    applyStimulus(1'b0, 11'd0, 11'd0, 3'b101, 3'b000, 1'b0, 1'b0);
    checkOutput("col_first_valid", 32'(rewardValid), 32'd1);
    checkOutput("col_first_type", 32'(rewardType), 32'(t0));
    checkOutput("col_first_active", 32'(presentActive), 32'b110);
    idleCycle();
    checkOutput("col_second_valid", 32'(rewardValid), 32'd1);
    checkOutput("col_second_type", 32'(rewardType), 32'(t2));
    checkOutput("col_second_active", 32'(presentActive), 32'b010);
    idleCycle();
    checkOutput("col_done_valid", 32'(rewardValid), 32'd0);
    checkOutput("col_slot1_kept", 32'(presentActive), 32'b010);

    $display("[TB] rope collisions");
    applyStimulus(1'b0, 11'd0, 11'd0, 3'b000, 3'b010, 1'b0, 1'b0);
    checkOutput("rope_off_valid", 32'(rewardValid), 32'd0);
    checkOutput("rope_off_active", 32'(presentActive), 32'b010);
    checkOutput("rope_on_valid", 32'(r_rewardValid), 32'd1);
    checkOutput("rope_on_type", 32'(r_rewardType), 32'(t1));
    checkOutput("rope_on_active", 32'(r_presentActive), 32'b000);

    $display("[TB] clearAll with pending rewards");
    t0 = mapType(m_lfsr);
    spawnAt(11'd11, 11'd12);
    spawnAt(11'd13, 11'd14);
    checkOutput("clr_setup_active", 32'(presentActive), 32'b111);
    applyStimulus(1'b0, 11'd0, 11'd0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkOutput("clr_first_reward", 32'(rewardValid), 32'd1);
    checkOutput("clr_first_type", 32'(rewardType), 32'(t0));
    applyStimulus(1'b0, 11'd0, 11'd0, 3'b000, 3'b000, 1'b0, 1'b1);
    checkOutput("clr_no_reward", 32'(rewardValid), 32'd0);
    checkOutput("clr_all_idle", 32'(presentActive), 32'b000);
    idleCycle();
    checkOutput("clr_pending_dropped", 32'(rewardValid), 32'd0);

    $display("[TB] async reset mid-fall");
    spawnAt(11'd5, 11'd100);
    frames(3);
    checkOutput("prefall_y0", 32'(topLeftY0), 32'd106);
    #3;
    resetN = 1'b0;
    #1;
    checkOutput("areset_active", 32'(presentActive), 32'd0);
    checkOutput("areset_visible", 32'(presentVisible), 32'd0);
    checkOutput("areset_x0", 32'(topLeftX0), 32'd0);
    checkOutput("areset_y0", 32'(topLeftY0), 32'd0);
    @(posedge clk); #1;
    resetN = 1'b1;

    $display("[TB] below-floor spawn and collect vs frame tick");
    spawnAt(11'd200, 11'd500);
    checkOutput("deep_y0", 32'(topLeftY0), 32'd500);
    frames(1);
    checkOutput("deep_clamp_y0", 32'(topLeftY0), 32'd384);
    checkOutput("deep_state", 32'(dut.state_q[0]), ST_LANDED);
    spawnAt(11'd1, 11'd10);
    checkOutput("tick_setup_y1", 32'(topLeftY1), 32'd10);
    applyStimulus(1'b0, 11'd0, 11'd0, 3'b010, 3'b000, 1'b1, 1'b0);
    checkOutput("tick_col_valid", 32'(rewardValid), 32'd1);
    checkOutput("tick_col_active", 32'(presentActive), 32'b001);
    checkOutput("tick_col_y1_held", 32'(topLeftY1), 32'd10);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/presents_manager.md
# presents_manager

Owns the lifetime of the three on-screen presents. Accepts spawn requests when a ball is popped and allocates them to free slots, with a pseudo-random present type. Moves falling presents once per frame and times landed presents until they blink and expire. Consumes the per-slot player/rope collision flags and serialises collections into one-cycle reward pulses for the game controller; its per-slot position and visibility outputs feed the present drawers.

## Interface
Parameters:
- FLOOR_Y, 400: y of floor; a present rests at FLOOR_Y-PRESENT_H.
- PRESENT_H, 16: present height in pixels.
- FALL_STEP, 2: pixels added to Y per frame while falling.
- LAND_FRAMES, 180: frames a landed present stays solid.
- BLINK_FRAMES, 60: frames of blinking before expiry.
- ROPE_COLLECTS, 0: 1 = rope collision also collects.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- clearAll  in  1  synchronous: all slots to IDLE, pending collects dropped.
- spawnReq  in  1  one-cycle spawn request.
- spawnX, spawnY  in  11 each  spawn top-left.
- colPlayer  in  3  bit i = col_player_present(i+1).
- colRope  in  3  bit i = col_rope_present(i+1).
- presentActive  out  3  slot i not IDLE.
- presentVisible  out  3  slot i drawn this frame.
- topLeftX0..2, topLeftY0..2  out  11 each  slot positions.
- presentType0..2  out  2  slot types, 0..2.
- rewardValid  out  1  one-cycle collect pulse.
- rewardType  out  2  type of collected present, valid with rewardValid.
- spawnDropped  out  1  one-cycle pulse: spawn with no free slot.

## Operation
- Per-slot FSM: IDLE -> FALLING -> LANDED -> BLINK -> IDLE; any non-IDLE state -> IDLE on collect or clearAll.
- Spawn: allocate the lowest-index IDLE slot. Load X/Y and type, and enter FALLING. If no slot is IDLE, pulse spawnDropped and change nothing.
- Type: 8-bit Fibonacci LFSR, seed 8'hA5, taps 8,6,5,4, advanced every clock. Type = lfsr[1:0], with 2'b11 mapped to 2'b00.
- FALLING, on startOfFrame:
  - Y <= min(Y+FALL_STEP, FLOOR_Y-PRESENT_H), computed in 12 bits so it cannot wrap.
  - On reaching the floor: LANDED, frame counter = LAND_FRAMES-1.
  - A spawnY already at or below the floor clamps and lands on its first frame tick.
- LANDED: counter decrements per startOfFrame. At 0 -> BLINK, counter = BLINK_FRAMES-1.
- BLINK:
  - Visible = counter[3] (toggles every 8 frames).
  - At counter 0 on startOfFrame -> IDLE.
- presentVisible = 1 in FALLING/LANDED; counter[3] in BLINK; 0 in IDLE.
- Collect detection:
  - colPlayer[i], or colRope[i] when ROPE_COLLECTS=1, in a non-IDLE slot sets pending[i] (sticky).
  - Collision inputs are pixel-level and sporadic, hence the latch.
  - Collision on an IDLE slot is ignored.
- Reward serialiser: each cycle, if any pending bit is set, take the lowest index i:
  - Pulse rewardValid with rewardType = presentType_i.
  - Clear pending[i]; slot i -> IDLE.
  - At most one reward per cycle; the others wait their turn.
- A slot with pending set is not IDLE, so it cannot be re-allocated before its reward issues.
- clearAll has priority over spawn, frame ticks, and rewards. No reward is issued in the clearAll cycle.

## Timing
- Reset (async): all slots IDLE, pending=0, LFSR=8'hA5, counters 0. All outputs 0.
- Spawn latency: presentActive/presentVisible/position set the cycle after spawnReq.
- Collect latency:
  - Single pending: rewardValid the cycle after the collision cycle; presentActive[i] low that same cycle.
  - k simultaneous pendings: rewards in k consecutive cycles, lowest index first.
- Frame-driven moves update the cycle after startOfFrame.
- Same-cycle spawn and expiry: the expiring slot is still non-IDLE, so it is not allocated that cycle.
- Same-cycle collect and startOfFrame: the collect wins, and the slot is not moved.
- Outputs are registered; no combinational input-to-output paths.

## Test plan
- Spawn at (100,50): slot 0 active next cycle, Y=50. After 167 frame ticks Y=384 and the slot is LANDED. After 180 more frames it is in BLINK, with visible toggling every 8 frames. After 60 more frames it is IDLE.
- Four spawnReq pulses with all slots idle: slots 0,1,2 fill in order, and the 4th pulses spawnDropped with no state change.
- colPlayer=3'b101 for one cycle with all slots active: rewardValid on the next two cycles, with slot 0's type then slot 2's. Slot 1 stays active.
- colRope[1] with ROPE_COLLECTS=0: no reward, slot stays. With ROPE_COLLECTS=1: reward next cycle.
- Assert clearAll while two rewards are pending: no rewardValid, all slots IDLE next cycle. Async resetN mid-fall: all outputs 0 immediately.
- spawnY=500 (below floor): Y clamps to 384 and the slot is LANDED after the first frame tick.
